regfile_op_sequencer: RTL



---
 rtl/regfile_ctrl_pkg.sv | 26 ++
 rtl/regfile_alu.sv | 39 +++
 rtl/regfile_op_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared widths, opcode and state encodings for the register file op sequencer.
package regfile_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_LDI = 3'd5,
    OP_MOV = 3'd6,
    OP_CLR = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_alu.sv
// Combinational ALU: produces the write-back value and carry/borrow for one instruction.
module regfile_alu
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = regfile_ctrl_pkg::DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] value,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum   = {1'b0, op_a} + {1'b0, op_b};
    value = '0;
    carry = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        value = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      OP_SUB: begin
        value = op_a - op_b;
        carry = (op_a < op_b);
      end
      OP_AND: value = op_a & op_b;
      OP_OR:  value = op_a | op_b;
      OP_XOR: value = op_a ^ op_b;
      OP_LDI: value = imm;
      OP_MOV: value = op_a;
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Accepts one instruction at a time, reads operands, executes, and writes back to the
// 16-entry register file; CLR sweeps every register to zero over 16 cycles.
module regfile_op_sequencer
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = regfile_ctrl_pkg::DATA_W,
  parameter int ADDR_W = regfile_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              RESET,
  // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready.
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [DATA_W-1:0] imm,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [ADDR_W-1:0] rf_read_addr_A,
  output logic [ADDR_W-1:0] rf_read_addr_B,
  input  logic [DATA_W-1:0] rf_read_data_A,
  input  logic [DATA_W-1:0] rf_read_data_B,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;
  localparam logic [ADDR_W-1:0] CNT_PRE  = CNT_LAST - 1'b1;

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [DATA_W:0]   exec_q;
  logic [ADDR_W-1:0] cnt;
  logic              we_q;
  logic [DATA_W-1:0] alu_value;
  logic              alu_carry;

  regfile_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (op_q),
    .op_a  (op_a_q),
    .op_b  (op_b_q),
    .imm   (imm_q),
    .value (alu_value),
    .carry (alu_carry)
  );

  // A reset cycle must never write the register file, even while a write is registered.
  assign rf_write_en = we_q & ~RESET;
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state          <= ST_IDLE;
      instr_ready    <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      we_q           <= 1'b0;
      rf_write_addr  <= '0;
      rf_write_data  <= '0;
      rf_read_addr_A <= '0;
      rf_read_addr_B <= '0;
      result         <= '0;
      zero_flag      <= 1'b0;
      carry_flag     <= 1'b0;
      op_q           <= '0;
      rd_q           <= '0;
      imm_q          <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      exec_q         <= '0;
      cnt            <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          we_q <= 1'b0;
          done <= 1'b0;
          if (instr_valid && instr_ready) begin
            op_q        <= op;
            rd_q        <= rd;
            imm_q       <= imm;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            if (op == OP_CLR) begin
              state         <= ST_CLEAR;
              cnt           <= '0;
              we_q          <= 1'b1;
              rf_write_addr <= '0;
              rf_write_data <= '0;
            end else begin
              // Read addresses are registered here so they are stable for the whole READ cycle.
              state          <= ST_READ;
              rf_read_addr_A <= rs;
              rf_read_addr_B <= rt;
            end
          end
        end
        ST_READ: begin
          op_a_q <= rf_read_data_A;
          op_b_q <= rf_read_data_B;
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          exec_q        <= {alu_carry, alu_value};
          we_q          <= 1'b1;
          rf_write_addr <= rd_q;
          rf_write_data <= alu_value;
          done          <= 1'b1;
          state         <= ST_WRITE;
        end
        ST_WRITE: begin
          we_q        <= 1'b0;
          done        <= 1'b0;
          result      <= exec_q[DATA_W-1:0];
          zero_flag   <= (exec_q[DATA_W-1:0] == '0);
          carry_flag  <= exec_q[DATA_W];
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        ST_CLEAR: begin
          if (cnt == CNT_LAST) begin
            we_q        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            zero_flag   <= 1'b1;
            carry_flag  <= 1'b0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            cnt           <= cnt + 1'b1;
            rf_write_addr <= cnt + 1'b1;
            // done is raised for the cycle that carries the last register's write.
            done          <= (cnt == CNT_PRE);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
